// File: rtl/data_bus.sv
// Data-side memory system: word RAM plus LED, timer and UART TX registers.
// Ports: clk, rst, mem_read_address/_data, mem_write_address/_data/_enable, led, uart_tx, uart_busy.
module data_bus #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RAM_WORDS    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_read_address,
  output logic [31:0] mem_read_data,
  input  logic [7:0]  mem_write_address,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_enable,
  output logic [7:0]  led,
  output logic        uart_tx,
  output logic        uart_busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic [6:0]  RAM_LIM  = 7'(RAM_WORDS);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [5:0]  IDX_LED  = 6'd60;
  localparam logic [5:0]  IDX_TMR  = 6'd61;
  localparam logic [5:0]  IDX_TX   = 6'd62;
  localparam logic [5:0]  IDX_ST   = 6'd63;

  logic [31:0] ram [RAM_WORDS];

  logic [5:0] rd_idx;
  logic [5:0] wr_idx;
  logic       rd_in_ram;
  logic       wr_in_ram;

  assign rd_idx    = mem_read_address[7:2];
  assign wr_idx    = mem_write_address[7:2];
  assign rd_in_ram = {1'b0, rd_idx} < RAM_LIM;
  assign wr_in_ram = {1'b0, wr_idx} < RAM_LIM;

  logic [7:0]  led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic        ovf_q, ovf_d;
  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic busy;
  logic wr_led;
  logic wr_tmr;
  logic wr_tx;
  logic wr_st;
  logic baud_done;

  assign busy      = (state_q != IDLE);
  assign wr_led    = mem_write_enable && (wr_idx == IDX_LED);
  assign wr_tmr    = mem_write_enable && (wr_idx == IDX_TMR);
  assign wr_tx     = mem_write_enable && (wr_idx == IDX_TX);
  assign wr_st     = mem_write_enable && (wr_idx == IDX_ST);
  assign baud_done = (baud_q == BAUD_MAX);

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_write_enable && wr_in_ram) begin
      ram[wr_idx] <= mem_write_data;
    end
  end

  always_comb begin
    mem_read_data = 32'd0;
    if (rd_in_ram) begin
      mem_read_data = ram[rd_idx];
    end else begin
      case (rd_idx)
        IDX_LED: mem_read_data = {24'd0, led_q};
        IDX_TMR: mem_read_data = timer_q;
        IDX_ST:  mem_read_data = {30'd0, ovf_q, busy};
        default: mem_read_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    led_d   = wr_led ? mem_write_data[7:0] : led_q;
    timer_d = wr_tmr ? mem_write_data : timer_q + 32'd1;
    ovf_d   = ovf_q;
    if (wr_st) begin
      ovf_d = 1'b0;
    end else if (wr_tx && busy) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (wr_tx) begin
          state_d = START;
          baud_d  = 16'd0;
          shift_d = mem_write_data[7:0];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = 16'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= 8'd0;
      timer_q <= 32'd0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      led_q   <= led_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign led       = led_q;
  assign uart_tx   = tx_q;
  assign uart_busy = busy;

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: RAM, LED, timer, UART frame, reset abort.
// Expected values are queued as stimulus is driven and popped when observed.
module tb_data_bus;

  logic        clk;
  logic        rst;
  logic [7:0]  ra;
  logic [31:0] rd;
  logic [7:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic [7:0]  led;
  logic        tx;
  logic        busy;

  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  data_bus #(
    .CLKS_PER_BIT(4),
    .RAM_WORDS(58)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read_address(ra),
    .mem_read_data(rd),
    .mem_write_address(wa),
    .mem_write_data(wd),
    .mem_write_enable(we),
    .led(led),
    .uart_tx(tx),
    .uart_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wa = a;
    wd = d;
    we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    we = 1'b0;
    wa = 8'd0;
    wd = 32'd0;
    ra = 8'd0;
    repeat (3) step();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h5);
    repeat (5) step();
    exp = exp_q.pop_front();
    n_checks++;
    if ({24'd0, led} !== exp) $display("FAIL reset_led got %h want %h", led, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, tx} !== exp) $display("FAIL reset_tx got %b want %h", tx, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, busy} !== exp) $display("FAIL reset_busy got %b want %h", busy, exp);
    else n_pass++;
    ra = 8'hFC;
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) $display("FAIL reset_status got %h want %h", rd, exp);
    else n_pass++;
    ra = 8'hF4;
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) $display("FAIL reset_timer got %h want %h", rd, exp);
    else n_pass++;
  endtask

  task automatic test_ram();
    logic [7:0] addrs [4];
    addrs[0] = 8'h10;
    addrs[1] = 8'h13;
    addrs[2] = 8'hE8;
    addrs[3] = 8'h14;
    wr(8'h10, 32'hDEADBEEF);
    wr(8'h14, 32'h12345678);
    wr(8'hE8, 32'hFFFFFFFF);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h12345678);
    for (int i = 0; i < 4; i++) begin
      ra = addrs[i];
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) $display("FAIL ram_rd[%h] got %h want %h", ra, rd, exp);
      else n_pass++;
    end
  endtask

  task automatic test_led();
    wr(8'hF0, 32'h000001A5);
    exp_q.push_back(32'hA5);
    exp_q.push_back(32'hA5);
    exp = exp_q.pop_front();
    n_checks++;
    if ({24'd0, led} !== exp) $display("FAIL led_out got %h want %h", led, exp);
    else n_pass++;
    ra = 8'hF0;
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) $display("FAIL led_rd got %h want %h", rd, exp);
    else n_pass++;
  endtask

  task automatic test_timer();
    ra = 8'hF4;
    wr(8'hF4, 32'hFFFFFFFE);
    exp_q.push_back(32'hFFFFFFFE);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h00000000);
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) $display("FAIL timer_rd%0d got %h want %h", i, rd, exp);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_uart();
    logic [7:0] byte_v;
    int busy_cnt;
    byte_v = 8'h55;
    busy_cnt = 0;
    ra = 8'hFC;
    wr(8'hF8, {24'd0, byte_v});
    for (int c = 0; c < 4; c++) exp_q.push_back(32'h0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 4; c++) exp_q.push_back({31'd0, byte_v[b]});
    for (int c = 0; c < 4; c++) exp_q.push_back(32'h1);
    for (int k = 0; k < 40; k++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if ({31'd0, tx} !== exp) $display("FAIL uart_tx_c%0d got %b want %h", k, tx, exp);
      else n_pass++;
      if (busy === 1'b1) busy_cnt++;
      if (k == 10) begin
        wa = 8'hF8;
        wd = 32'hAA;
        we = 1'b1;
      end
      if (k == 11) begin
        we = 1'b0;
        exp_q.push_front(32'h3);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) $display("FAIL uart_ovf_st got %h want %h", rd, exp);
        else n_pass++;
      end
      step();
    end
    exp_q.push_back(32'd40);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    if (busy === 1'b1) busy_cnt++;
    exp = exp_q.pop_front();
    n_checks++;
    if (busy_cnt !== int'(exp)) $display("FAIL uart_busy_len got %0d want %0d", busy_cnt, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, tx} !== exp) $display("FAIL uart_idle_tx got %b want %h", tx, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) $display("FAIL uart_st_idle got %h want %h", rd, exp);
    else n_pass++;
    wr(8'hFC, 32'h0);
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (rd !== exp) $display("FAIL uart_st_clr got %h want %h", rd, exp);
    else n_pass++;
  endtask

  task automatic test_rst_midframe();
    wr(8'hF0, 32'h3C);
    wr(8'hF8, 32'h00);
    repeat (14) step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, tx} !== exp) $display("FAIL mid_tx got %b want %h", tx, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, busy} !== exp) $display("FAIL mid_busy got %b want %h", busy, exp);
    else n_pass++;
    rst = 1'b1;
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, tx} !== exp) $display("FAIL arst_tx got %b want %h", tx, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if ({31'd0, busy} !== exp) $display("FAIL arst_busy got %b want %h", busy, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if ({24'd0, led} !== exp) $display("FAIL arst_led got %h want %h", led, exp);
    else n_pass++;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_uart();
    test_rst_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
